fft_sequencer: RTL and testbench

- Parametrised layer sequencer and bus arbiter for the in-place FFT datapath.
- Owns the shared RAM/twiddle-ROM bus. Steps through one scramble layer and log2(FFT_SIZE) butterfly layers using per-layer done handshakes.
- Inserts a pipeline-drain gap between butterfly layers so the last writes land before the next layer reads.
- Adds start/busy/done handshake, forward/inverse mode latch, per-layer watchdog and execution-cycle counter.

---
 rtl/fft_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fft_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sequencer.sv
// Layer sequencer and shared RAM/twiddle-ROM bus arbiter for the in-place FFT.
// Walks the scramble layer and every butterfly layer, with a drain gap, watchdog and cycle counter.
module fft_sequencer #(
  parameter int FFT_SIZE       = 8,
  parameter int NUM_LAYERS     = $clog2(FFT_SIZE) + 1,
  parameter int ADDR_SIZE      = $clog2(2 * FFT_SIZE),
  parameter int TWID_ADDR_SIZE = 7,
  parameter int WORD_SIZE      = 74,
  parameter int PIPE_LATENCY   = 4,
  parameter int LAYER_TIMEOUT  = 1023,
  parameter int CYCLE_W        = 16
) (
  input  logic                                 i_CLK,
  input  logic                                 i_RST,
  input  logic                                 i_start,
  input  logic                                 i_inverse,
  input  logic [NUM_LAYERS-1:0]                i_layer_done,
  input  logic [NUM_LAYERS-1:0]                i_layer_rden,
  input  logic [NUM_LAYERS-1:0]                i_layer_wren,
  input  logic [NUM_LAYERS*ADDR_SIZE-1:0]      i_layer_rdaddr_A,
  input  logic [NUM_LAYERS*ADDR_SIZE-1:0]      i_layer_rdaddr_B,
  input  logic [NUM_LAYERS*TWID_ADDR_SIZE-1:0] i_layer_rdaddr_tw,
  input  logic [ADDR_SIZE-1:0]                 i_scr_wraddr_A,
  input  logic [ADDR_SIZE-1:0]                 i_scr_wraddr_B,
  input  logic [WORD_SIZE-1:0]                 i_scr_wrdata_A,
  input  logic [WORD_SIZE-1:0]                 i_scr_wrdata_B,
  input  logic                                 i_pipe_wren,
  input  logic [ADDR_SIZE-1:0]                 i_pipe_wraddr_A,
  input  logic [ADDR_SIZE-1:0]                 i_pipe_wraddr_B,
  input  logic [WORD_SIZE-1:0]                 i_pipe_wrdata_A,
  input  logic [WORD_SIZE-1:0]                 i_pipe_wrdata_B,
  output logic [NUM_LAYERS-1:0]                o_cs,
  output logic [$clog2(NUM_LAYERS)-1:0]        o_layer_sel,
  output logic                                 o_bus_rden,
  output logic                                 o_bus_wren,
  output logic [ADDR_SIZE-1:0]                 o_bus_rdaddr_A,
  output logic [ADDR_SIZE-1:0]                 o_bus_rdaddr_B,
  output logic [ADDR_SIZE-1:0]                 o_bus_wraddr_A,
  output logic [ADDR_SIZE-1:0]                 o_bus_wraddr_B,
  output logic [TWID_ADDR_SIZE-1:0]            o_bus_twaddr,
  output logic [WORD_SIZE-1:0]                 o_bus_wrdata_A,
  output logic [WORD_SIZE-1:0]                 o_bus_wrdata_B,
  output logic                                 o_inverse,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_error,
  output logic [CYCLE_W-1:0]                   o_cycles
);

  localparam int SEL_W = $clog2(NUM_LAYERS);
  localparam int WD_W  = $clog2(LAYER_TIMEOUT + 1);
  localparam int DR_W  = $clog2(PIPE_LATENCY + 2);
  localparam logic [SEL_W-1:0] LAST_LAYER = SEL_W'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   layer_sel, layer_sel_nxt;
  logic [WD_W-1:0]    wd_cnt, wd_cnt_nxt;
  logic [DR_W-1:0]    drain_cnt, drain_cnt_nxt;
  logic               err_q, err_nxt;
  logic               inv_q, inv_nxt;
  logic [CYCLE_W-1:0] cycles_q, cycles_nxt;

  // NOTE: every variable gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    layer_sel_nxt = layer_sel;
    wd_cnt_nxt    = wd_cnt;
    drain_cnt_nxt = drain_cnt;
    err_nxt       = err_q;
    inv_nxt       = inv_q;
    cycles_nxt    = cycles_q;
    if (state != S_IDLE && !(&cycles_q)) cycles_nxt = cycles_q + CYCLE_W'(1);

    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt     = S_RUN;
          layer_sel_nxt = '0;
          wd_cnt_nxt    = '0;
          err_nxt       = 1'b0;
          inv_nxt       = i_inverse;
          cycles_nxt    = '0;
        end
      end
      S_RUN: begin
        if (i_layer_done[layer_sel]) begin
          wd_cnt_nxt = '0;
          if (layer_sel != '0 && PIPE_LATENCY > 0) begin
            state_nxt     = S_DRAIN;
            drain_cnt_nxt = DR_W'(PIPE_LATENCY);
          end else if (layer_sel == LAST_LAYER) begin
            state_nxt = S_FINISH;
          end else begin
            layer_sel_nxt = layer_sel + SEL_W'(1);
          end
        end else if (wd_cnt == WD_W'(LAYER_TIMEOUT - 1)) begin
          // The layer has now been selected for LAYER_TIMEOUT cycles without finishing.
          state_nxt  = S_IDLE;
          err_nxt    = 1'b1;
          wd_cnt_nxt = '0;
        end else begin
          wd_cnt_nxt = wd_cnt + WD_W'(1);
        end
      end
      S_DRAIN: begin
        drain_cnt_nxt = drain_cnt - DR_W'(1);
        if (drain_cnt == DR_W'(1)) begin
          if (layer_sel == LAST_LAYER) begin
            state_nxt = S_FINISH;
          end else begin
            state_nxt     = S_RUN;
            layer_sel_nxt = layer_sel + SEL_W'(1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state     <= S_IDLE;
      layer_sel <= '0;
      wd_cnt    <= '0;
      drain_cnt <= '0;
      err_q     <= 1'b0;
      inv_q     <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state     <= state_nxt;
      layer_sel <= layer_sel_nxt;
      wd_cnt    <= wd_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      err_q     <= err_nxt;
      inv_q     <= inv_nxt;
      cycles_q  <= cycles_nxt;
    end
  end

  // Bus mux: the selected layer owns the bus in RUN; only pipe writes may still land while draining.
  always_comb begin
    o_cs           = '0;
    o_bus_rden     = 1'b0;
    o_bus_wren     = 1'b0;
    o_bus_rdaddr_A = '0;
    o_bus_rdaddr_B = '0;
    o_bus_wraddr_A = '0;
    o_bus_wraddr_B = '0;
    o_bus_twaddr   = '0;
    o_bus_wrdata_A = i_pipe_wrdata_A;
    o_bus_wrdata_B = i_pipe_wrdata_B;
    case (state)
      S_RUN: begin
        o_cs           = NUM_LAYERS'(1) << layer_sel;
        o_bus_rden     = i_layer_rden[layer_sel];
        o_bus_wren     = i_layer_wren[layer_sel];
        o_bus_rdaddr_A = i_layer_rdaddr_A[int'(layer_sel)*ADDR_SIZE +: ADDR_SIZE];
        o_bus_rdaddr_B = i_layer_rdaddr_B[int'(layer_sel)*ADDR_SIZE +: ADDR_SIZE];
        if (layer_sel == '0) begin
          o_bus_wraddr_A = i_scr_wraddr_A;
          o_bus_wraddr_B = i_scr_wraddr_B;
          o_bus_wrdata_A = i_scr_wrdata_A;
          o_bus_wrdata_B = i_scr_wrdata_B;
        end else begin
          o_bus_twaddr   = i_layer_rdaddr_tw[int'(layer_sel)*TWID_ADDR_SIZE +: TWID_ADDR_SIZE];
          o_bus_wraddr_A = i_pipe_wraddr_A;
          o_bus_wraddr_B = i_pipe_wraddr_B;
        end
      end
      S_DRAIN: begin
        o_bus_wren     = i_pipe_wren;
        o_bus_wraddr_A = i_pipe_wraddr_A;
        o_bus_wraddr_B = i_pipe_wraddr_B;
      end
      default: ;
    endcase
  end

  assign o_layer_sel = layer_sel;
  assign o_busy      = (state == S_RUN) || (state == S_DRAIN);
  assign o_done      = (state == S_FINISH);
  assign o_error     = err_q;
  assign o_inverse   = inv_q;
  assign o_cycles    = cycles_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench for fft_sequencer: table of transforms plus randomized runs against a timeline model,
// with hand-written watchdog and mid-run reset sequences.
module tb_fft_sequencer;

  localparam int NL = 4, AW = 4, TW = 7, WW = 74, PL = 4, LT = 20, CW = 16;

  typedef enum int {PH_IDLE, PH_RUN, PH_DRAIN, PH_FINISH} ph_t;
  typedef struct { ph_t ph; int ly; bit dn; } ent_t;
  typedef struct { bit use0; bit inv; bit hold; int gap; int lat; int exp_cycles; } vec_t;

  logic i_CLK = 1'b0;
  logic i_RST, i_start, i_start0, i_inverse, i_pipe_wren;
  logic [NL-1:0] i_layer_done, i_layer_done0, i_layer_rden, i_layer_wren;
  logic [NL*AW-1:0] i_layer_rdaddr_A, i_layer_rdaddr_B;
  logic [NL*TW-1:0] i_layer_rdaddr_tw;
  logic [AW-1:0] i_scr_wraddr_A, i_scr_wraddr_B, i_pipe_wraddr_A, i_pipe_wraddr_B;
  logic [WW-1:0] i_scr_wrdata_A, i_scr_wrdata_B, i_pipe_wrdata_A, i_pipe_wrdata_B;

  logic [NL-1:0] o_cs, z_cs;
  logic [1:0] o_layer_sel, z_layer_sel;
  logic o_bus_rden, o_bus_wren, z_bus_rden, z_bus_wren;
  logic [AW-1:0] o_bus_rdaddr_A, o_bus_rdaddr_B, o_bus_wraddr_A, o_bus_wraddr_B;
  logic [AW-1:0] z_bus_rdaddr_A, z_bus_rdaddr_B, z_bus_wraddr_A, z_bus_wraddr_B;
  logic [TW-1:0] o_bus_twaddr, z_bus_twaddr;
  logic [WW-1:0] o_bus_wrdata_A, o_bus_wrdata_B, z_bus_wrdata_A, z_bus_wrdata_B;
  logic o_inverse, o_busy, o_done, o_error, z_inverse, z_busy, z_done, z_error;
  logic [CW-1:0] o_cycles, z_cycles;

  int n_vec = 0, n_bad = 0;
  int m_cyc[2], m_inv[2], m_err[2];

  fft_sequencer #(.FFT_SIZE(8), .PIPE_LATENCY(PL), .LAYER_TIMEOUT(LT)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_start(i_start), .i_inverse(i_inverse),
    .i_layer_done(i_layer_done), .i_layer_rden(i_layer_rden), .i_layer_wren(i_layer_wren),
    .i_layer_rdaddr_A(i_layer_rdaddr_A), .i_layer_rdaddr_B(i_layer_rdaddr_B),
    .i_layer_rdaddr_tw(i_layer_rdaddr_tw),
    .i_scr_wraddr_A(i_scr_wraddr_A), .i_scr_wraddr_B(i_scr_wraddr_B),
    .i_scr_wrdata_A(i_scr_wrdata_A), .i_scr_wrdata_B(i_scr_wrdata_B),
    .i_pipe_wren(i_pipe_wren), .i_pipe_wraddr_A(i_pipe_wraddr_A), .i_pipe_wraddr_B(i_pipe_wraddr_B),
    .i_pipe_wrdata_A(i_pipe_wrdata_A), .i_pipe_wrdata_B(i_pipe_wrdata_B),
    .o_cs(o_cs), .o_layer_sel(o_layer_sel), .o_bus_rden(o_bus_rden), .o_bus_wren(o_bus_wren),
    .o_bus_rdaddr_A(o_bus_rdaddr_A), .o_bus_rdaddr_B(o_bus_rdaddr_B),
    .o_bus_wraddr_A(o_bus_wraddr_A), .o_bus_wraddr_B(o_bus_wraddr_B),
    .o_bus_twaddr(o_bus_twaddr), .o_bus_wrdata_A(o_bus_wrdata_A), .o_bus_wrdata_B(o_bus_wrdata_B),
    .o_inverse(o_inverse), .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_cycles(o_cycles)
  );

  // Second instance without a drain gap; shares the bus inputs but has its own start/done.
  fft_sequencer #(.FFT_SIZE(8), .PIPE_LATENCY(0), .LAYER_TIMEOUT(LT)) dut0 (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_start(i_start0), .i_inverse(i_inverse),
    .i_layer_done(i_layer_done0), .i_layer_rden(i_layer_rden), .i_layer_wren(i_layer_wren),
    .i_layer_rdaddr_A(i_layer_rdaddr_A), .i_layer_rdaddr_B(i_layer_rdaddr_B),
    .i_layer_rdaddr_tw(i_layer_rdaddr_tw),
    .i_scr_wraddr_A(i_scr_wraddr_A), .i_scr_wraddr_B(i_scr_wraddr_B),
    .i_scr_wrdata_A(i_scr_wrdata_A), .i_scr_wrdata_B(i_scr_wrdata_B),
    .i_pipe_wren(i_pipe_wren), .i_pipe_wraddr_A(i_pipe_wraddr_A), .i_pipe_wraddr_B(i_pipe_wraddr_B),
    .i_pipe_wrdata_A(i_pipe_wrdata_A), .i_pipe_wrdata_B(i_pipe_wrdata_B),
    .o_cs(z_cs), .o_layer_sel(z_layer_sel), .o_bus_rden(z_bus_rden), .o_bus_wren(z_bus_wren),
    .o_bus_rdaddr_A(z_bus_rdaddr_A), .o_bus_rdaddr_B(z_bus_rdaddr_B),
    .o_bus_wraddr_A(z_bus_wraddr_A), .o_bus_wraddr_B(z_bus_wraddr_B),
    .o_bus_twaddr(z_bus_twaddr), .o_bus_wrdata_A(z_bus_wrdata_A), .o_bus_wrdata_B(z_bus_wrdata_B),
    .o_inverse(z_inverse), .o_busy(z_busy), .o_done(z_done), .o_error(z_error), .o_cycles(z_cycles)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_CLK);
    #2;
  endtask

  function automatic int sat(input int n);
    return (n > (2**CW) - 1) ? (2**CW) - 1 : n;
  endfunction

  function automatic logic [WW-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[WW-1:0];
  endfunction

  task automatic rand_bus();
    i_layer_rden      = NL'($urandom());
    i_layer_wren      = NL'($urandom());
    i_layer_rdaddr_A  = (NL*AW)'($urandom());
    i_layer_rdaddr_B  = (NL*AW)'($urandom());
    i_layer_rdaddr_tw = (NL*TW)'($urandom());
    i_scr_wraddr_A    = AW'($urandom());
    i_scr_wraddr_B    = AW'($urandom());
    i_pipe_wraddr_A   = AW'($urandom());
    i_pipe_wraddr_B   = AW'($urandom());
    i_pipe_wren       = 1'($urandom());
    i_scr_wrdata_A    = rand_word();
    i_scr_wrdata_B    = rand_word();
    i_pipe_wrdata_A   = rand_word();
    i_pipe_wrdata_B   = rand_word();
  endtask

  task automatic drive_done(input bit z, input logic [NL-1:0] d);
    i_layer_done  = z ? '0 : d;
    i_layer_done0 = z ? d : '0;
  endtask

  // Expected outputs for one cycle, derived from which phase/layer the model says we are in.
  task automatic cmp_cycle(input string tag, input ph_t ph, input int ly, input bit z,
                           input int e_cyc, input bit e_inv, input bit e_err);
    bit run, dr;
    logic [NL-1:0] e_cs;
    run  = (ph == PH_RUN);
    dr   = (ph == PH_DRAIN);
    e_cs = run ? (NL'(1) << ly) : '0;
    check({tag, " cs"},     z ? z_cs : o_cs, e_cs);
    check({tag, " busy"},   z ? z_busy : o_busy, run || dr);
    check({tag, " done"},   z ? z_done : o_done, ph == PH_FINISH);
    check({tag, " error"},  z ? z_error : o_error, e_err);
    check({tag, " inv"},    z ? z_inverse : o_inverse, e_inv);
    check({tag, " cycles"}, z ? z_cycles : o_cycles, e_cyc);
    if (run || dr) check({tag, " sel"}, z ? z_layer_sel : o_layer_sel, ly);
    if (!z) begin
      check({tag, " rden"}, o_bus_rden, run ? i_layer_rden[ly] : 1'b0);
      check({tag, " wren"}, o_bus_wren, run ? i_layer_wren[ly] : (dr ? i_pipe_wren : 1'b0));
      if (!dr) begin
        check({tag, " rdA"}, o_bus_rdaddr_A, run ? i_layer_rdaddr_A[ly*AW +: AW] : '0);
        check({tag, " rdB"}, o_bus_rdaddr_B, run ? i_layer_rdaddr_B[ly*AW +: AW] : '0);
        check({tag, " tw"},  o_bus_twaddr, (run && ly != 0) ? i_layer_rdaddr_tw[ly*TW +: TW] : '0);
      end
      check({tag, " wrA"}, o_bus_wraddr_A,
            (run && ly == 0) ? i_scr_wraddr_A : ((run || dr) ? i_pipe_wraddr_A : '0));
      check({tag, " wrB"}, o_bus_wraddr_B,
            (run && ly == 0) ? i_scr_wraddr_B : ((run || dr) ? i_pipe_wraddr_B : '0));
      check({tag, " wdA"}, o_bus_wrdata_A, (run && ly == 0) ? i_scr_wrdata_A : i_pipe_wrdata_A);
      check({tag, " wdB"}, o_bus_wrdata_B, (run && ly == 0) ? i_scr_wrdata_B : i_pipe_wrdata_B);
    end
  endtask

  task automatic chk_core(input string tag, input logic [NL-1:0] cs, input int sel, input bit busy,
                          input bit done, input bit err, input int cyc, input bit inv);
    check({tag, " cs"}, o_cs, cs);
    if (sel >= 0) check({tag, " sel"}, o_layer_sel, sel);
    check({tag, " busy"}, o_busy, busy);
    check({tag, " done"}, o_done, done);
    check({tag, " error"}, o_error, err);
    check({tag, " cycles"}, o_cycles, cyc);
    check({tag, " inv"}, o_inverse, inv);
  endtask

  // One whole transform: build the expected phase timeline, then drive and compare cycle by cycle.
  task automatic run_transform(input vec_t v, input int lat[NL]);
    ent_t tl[$];
    int z, pl;
    logic [NL-1:0] oh, rnd;
    z  = v.use0 ? 1 : 0;
    pl = v.use0 ? 0 : PL;
    for (int n = 0; n < NL; n++) begin
      for (int c = 1; c <= lat[n]; c++) tl.push_back('{PH_RUN, n, bit'(c == lat[n])});
      if (n >= 1 && pl > 0) for (int d = 0; d < pl; d++) tl.push_back('{PH_DRAIN, n, 1'b0});
    end
    tl.push_back('{PH_FINISH, NL - 1, 1'b0});

    for (int g = 0; g < v.gap; g++) begin
      tick();
      i_start = 1'b0; i_start0 = 1'b0; i_inverse = 1'($urandom());
      rand_bus(); drive_done(v.use0, NL'($urandom()));
      #2 cmp_cycle("idle", PH_IDLE, 0, v.use0, m_cyc[z], m_inv[z][0], m_err[z][0]);
    end
    tick();
    i_start = !v.use0; i_start0 = v.use0; i_inverse = v.inv;
    rand_bus(); drive_done(v.use0, NL'($urandom()));
    #2 cmp_cycle("start", PH_IDLE, 0, v.use0, m_cyc[z], m_inv[z][0], m_err[z][0]);
    m_inv[z] = v.inv;
    m_err[z] = 0;

    foreach (tl[j]) begin
      tick();
      i_start = v.hold && !v.use0; i_start0 = v.hold && v.use0; i_inverse = 1'($urandom());
      rand_bus();
      oh  = NL'(1) << tl[j].ly;
      rnd = NL'($urandom());
      if (tl[j].ph == PH_RUN) drive_done(v.use0, (rnd & ~oh) | (tl[j].dn ? oh : '0));
      else drive_done(v.use0, rnd);
      #2 cmp_cycle("run", tl[j].ph, tl[j].ly, v.use0, sat(j), v.inv, 1'b0);
    end
    m_cyc[z] = sat(tl.size());

    if (!v.hold) begin
      tick();
      i_start = 1'b0; i_start0 = 1'b0; i_inverse = 1'($urandom());
      rand_bus(); drive_done(v.use0, NL'($urandom()));
      #2 cmp_cycle("post", PH_IDLE, 0, v.use0, m_cyc[z], v.inv, 1'b0);
      if (v.exp_cycles >= 0) check("total cycles", v.use0 ? z_cycles : o_cycles, v.exp_cycles);
    end
  endtask

  initial begin
    vec_t vecs[8];
    int lat[NL];
    int k;
    // use0 inv hold gap lat exp_cycles (lat 0 = random per layer, exp -1 = model only)
    vecs[0] = '{1'b0, 1'b1, 1'b0, 2, 8, 45};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2, 8, 33};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1, 2, 21};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 0, 1, 17};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 3, 0, -1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1, 1, 5};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1, 0, -1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 2, 0, -1};

    i_RST = 1'b1; i_start = 1'b0; i_start0 = 1'b0; i_inverse = 1'b0;
    drive_done(1'b0, '0); rand_bus();
    repeat (3) tick();
    chk_core("reset", '0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("reset rden", o_bus_rden, 1'b0);
    check("reset wren", o_bus_wren, 1'b0);
    check("reset z cycles", z_cycles, 0);
    check("reset z busy", z_busy, 1'b0);
    i_RST = 1'b0;

    // Watchdog: layer 1 never finishes while the other done bits are held high.
    tick(); i_start = 1'b1; i_inverse = 1'b1;
    #2 chk_core("wd idle", '0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick(); i_start = 1'b0; i_inverse = 1'b0; drive_done(1'b0, (c == 3) ? 4'b0001 : 4'b0000);
      #2 chk_core("wd l0", 4'b0001, 0, 1'b1, 1'b0, 1'b0, c - 1, 1'b1);
    end
    for (int c = 1; c <= LT; c++) begin
      tick(); drive_done(1'b0, 4'b1101);
      #2 chk_core("wd l1", 4'b0010, 1, 1'b1, 1'b0, 1'b0, 3 + c - 1, 1'b1);
    end
    for (int c = 0; c < 3; c++) begin
      tick(); drive_done(1'b0, 4'b0000);
      #2 chk_core("wd abort", '0, -1, 1'b0, 1'b0, 1'b1, 3 + LT, 1'b1);
    end

    // Restart clears the error, then reset lands during the drain after layer 2.
    tick(); i_start = 1'b1; i_inverse = 1'b1;
    #2 chk_core("rs start", '0, -1, 1'b0, 1'b0, 1'b1, 3 + LT, 1'b1);
    k = 0;
    tick(); i_start = 1'b0; i_inverse = 1'b0; drive_done(1'b0, 4'b0001);
    #2 chk_core("rs l0", 4'b0001, 0, 1'b1, 1'b0, 1'b0, k++, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      tick(); drive_done(1'b0, (c == 2) ? 4'b0010 : 4'b0000);
      #2 chk_core("rs l1", 4'b0010, 1, 1'b1, 1'b0, 1'b0, k++, 1'b1);
    end
    for (int c = 0; c < PL; c++) begin
      tick(); drive_done(1'b0, 4'b0000);
      #2 chk_core("rs drain1", '0, 1, 1'b1, 1'b0, 1'b0, k++, 1'b1);
    end
    for (int c = 1; c <= 2; c++) begin
      tick(); drive_done(1'b0, (c == 2) ? 4'b0100 : 4'b0000);
      #2 chk_core("rs l2", 4'b0100, 2, 1'b1, 1'b0, 1'b0, k++, 1'b1);
    end
    tick(); drive_done(1'b0, 4'b0000);
    #2 chk_core("rs drain2", '0, 2, 1'b1, 1'b0, 1'b0, k++, 1'b1);
    tick(); i_RST = 1'b1;
    #2 chk_core("rs drain2b", '0, 2, 1'b1, 1'b0, 1'b0, k++, 1'b1);
    tick(); i_RST = 1'b0;
    #2 chk_core("rs after", '0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      #2 chk_core("rs idle", '0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end
    m_cyc = '{0, 0}; m_inv = '{0, 0}; m_err = '{0, 0};

    foreach (vecs[i]) begin
      for (int n = 0; n < NL; n++) lat[n] = (vecs[i].lat != 0) ? vecs[i].lat : $urandom_range(1, 8);
      run_transform(vecs[i], lat);
    end

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      v = '{1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 2), 0, -1};
      for (int n = 0; n < NL; n++) lat[n] = $urandom_range(1, 8);
      run_transform(v, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
